// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
//
// Holds the word and byte-mask types plus the memory-port arbiter state
// encoding and grant-side constants used by mem_port_arbiter and arb_grant_sel.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    // Encoding of the last_grant register / grant side.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // True while a physical transaction is outstanding.
    function automatic logic arb_is_serving(arb_state_t s);
        return (s == SERVE_I) || (s == SERVE_D);
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Grant policy for the memory-port arbiter.
//
// Purely combinational. Decides whether the data side wins the physical port
// in the current IDLE evaluation.
//
// Ports:
//   i_req      in  fetch side is requesting
//   d_req      in  data side is requesting (read or write)
//   last_grant in  side granted most recently (GRANT_I / GRANT_D)
//   grant_d    out 1 = data side wins, 0 = fetch side wins (if it requests)
//
// Build option: ARB_ROUND_ROBIN_EN
//   undefined - fixed priority, data over fetch; last_grant is ignored
//   defined   - ties go to the side that was not granted last
module arb_grant_sel
    import lc3b_types::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_d
);

`ifdef ARB_ROUND_ROBIN_EN
    // Only a real tie consults history; a lone requester always wins.
    assign grant_d = d_req & (~i_req | (last_grant == GRANT_I));
`else
    assign grant_d = d_req;

    logic unused_policy_inputs;
    assign unused_policy_inputs = i_req ^ last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-client memory port arbiter.
//
// Merges the read-only instruction-fetch port and the read/write data port
// onto a single physical memory interface. The winner's address, store data
// and byte mask are captured at grant, so the pipeline may change its request
// lines while an access is in flight. The losing client simply keeps its
// request asserted and is evaluated again in the next IDLE cycle.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   i_read, i_addr               fetch request (held until i_resp)
//   i_rdata, i_resp              fetch read data / one-cycle completion
//   d_read, d_write, d_addr,     data request (held until d_resp); read and
//   d_wdata, d_wmask             write together is treated as a write
//   d_rdata, d_resp              load data / one-cycle completion
//   pmem_read, pmem_write,       registered physical strobes and payload
//   pmem_addr, pmem_wdata,
//   pmem_wmask
//   pmem_rdata, pmem_resp        physical read data / completion
//
// Build option: ARB_ROUND_ROBIN_EN enables round-robin tie breaking in
// arb_grant_sel and the last_grant register here; default is fixed priority
// with the data side winning.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_wmask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [1:0]        pmem_wmask,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state_q, state_d;

    logic              pmem_read_q,  pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_addr_q,  pmem_addr_d;
    logic [DATA_W-1:0] pmem_wdata_q, pmem_wdata_d;
    lc3b_mem_wmask     pmem_wmask_q, pmem_wmask_d;

    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic i_req;
    logic d_req;
    logic grant_d;
    logic last_grant;
    logic grant;
    logic done;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // A grant happens only from IDLE; done marks the completing cycle.
    assign grant = (state_q == IDLE) & (i_req | d_req);
    assign done  = arb_is_serving(state_q) & pmem_resp;

    arb_grant_sel u_grant_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_d    (grant_d)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant) begin
            last_grant_d = grant_d ? GRANT_D : GRANT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GRANT_I;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    state_d = grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Physical port payload, captured at grant and held until completion
    // ------------------------------------------------------------------
    always_comb begin
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        pmem_wmask_d = pmem_wmask_q;

        if (grant) begin
            if (grant_d) begin
                // Read and write together is a write.
                pmem_read_d  = ~d_write;
                pmem_write_d = d_write;
                pmem_addr_d  = d_addr;
                pmem_wdata_d = d_wdata;
                pmem_wmask_d = d_wmask;
            end else begin
                pmem_read_d  = 1'b1;
                pmem_write_d = 1'b0;
                pmem_addr_d  = i_addr;
                pmem_wdata_d = '0;
                pmem_wmask_d = '0;
            end
        end else if (done) begin
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            pmem_wmask_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            pmem_wmask_q <= pmem_wmask_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Responses are suppressed during reset so an aborted access never
        // completes, even if memory answers in the reset cycle.
        i_resp = ~reset & (state_q == SERVE_I) & pmem_resp;
        d_resp = ~reset & (state_q == SERVE_D) & pmem_resp;

        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (i_resp) begin
            i_rdata_d = pmem_rdata;
        end
        if (d_resp & ~pmem_write_q) begin
            d_rdata_d = pmem_rdata;
        end

        // Read data follows memory in the response cycle, else holds.
        i_rdata = i_rdata_d;
        d_rdata = d_rdata_d;
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;
    assign pmem_wmask = pmem_wmask_q;

endmodule
